// File: rtl/envelope_control_sequencer_pkg.sv
// Shared types and constants for the envelope control sequencer.
//   VoiceOperatorID_t   : sweep / config address type (8 bits)
//   EnvelopeField_t     : config field selector (AttackLevel .. ReleaseRate)
//   field_strobe()      : one-hot write strobe for a field, 0 for illegal fields
//   field_legal()       : 1 when the field selects a real config table
package envelope_control_sequencer_pkg;

  localparam int NUM_VOICE_OPERATORS = 256;
  localparam int NUM_VOICES          = 32;
  localparam int ENV_FIELD_COUNT     = 5;

  typedef logic [7:0] VoiceOperatorID_t;

  localparam VoiceOperatorID_t LAST_OP = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

  typedef enum logic [2:0] {
    ENV_ATTACK_LEVEL  = 3'd0,
    ENV_SUSTAIN_LEVEL = 3'd1,
    ENV_ATTACK_RATE   = 3'd2,
    ENV_DECAY_RATE    = 3'd3,
    ENV_RELEASE_RATE  = 3'd4
  } EnvelopeField_t;

  function automatic logic [ENV_FIELD_COUNT-1:0] field_strobe(input logic [2:0] field);
    logic [ENV_FIELD_COUNT-1:0] s;
    s = '0;
    case (EnvelopeField_t'(field))
      ENV_ATTACK_LEVEL:  s = 5'b00001;
      ENV_SUSTAIN_LEVEL: s = 5'b00010;
      ENV_ATTACK_RATE:   s = 5'b00100;
      ENV_DECAY_RATE:    s = 5'b01000;
      ENV_RELEASE_RATE:  s = 5'b10000;
      default:           s = '0;
    endcase
    return s;
  endfunction

  function automatic logic field_legal(input logic [2:0] field);
    return field < 3'(ENV_FIELD_COUNT);
  endfunction

endpackage

// File: rtl/envelope_control_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
//   Host / loader config write requests (valid/ready handshake + field/addr/data),
//   note command strobe, sweep outputs and the stage's config write port.
//   slave  : sequencer side
//   master : environment side (requesters, note source, stage)
interface envelope_control_sequencer_if;
  import envelope_control_sequencer_pkg::*;

  logic             i_HostWrValid;
  logic             o_HostWrReady;
  logic [2:0]       i_HostWrField;
  VoiceOperatorID_t i_HostWrAddr;
  logic [15:0]      i_HostWrData;

  logic             i_LoadWrValid;
  logic             o_LoadWrReady;
  logic [2:0]       i_LoadWrField;
  VoiceOperatorID_t i_LoadWrAddr;
  logic [15:0]      i_LoadWrData;

  logic             i_NoteValid;
  logic [4:0]       i_NoteVoice;
  logic             i_NoteOn;

  VoiceOperatorID_t o_VoiceOperator;
  logic             o_NoteOn;
  logic [4:0]       o_EnvelopeConfigWriteEnable;
  VoiceOperatorID_t o_ConfigWriteAddr;
  logic [15:0]      o_ConfigWriteData;
  logic             o_ConfigError;

  modport slave (
    input  i_HostWrValid, i_HostWrField, i_HostWrAddr, i_HostWrData,
    input  i_LoadWrValid, i_LoadWrField, i_LoadWrAddr, i_LoadWrData,
    input  i_NoteValid, i_NoteVoice, i_NoteOn,
    output o_HostWrReady, o_LoadWrReady,
    output o_VoiceOperator, o_NoteOn,
    output o_EnvelopeConfigWriteEnable, o_ConfigWriteAddr, o_ConfigWriteData, o_ConfigError
  );

  modport master (
    output i_HostWrValid, i_HostWrField, i_HostWrAddr, i_HostWrData,
    output i_LoadWrValid, i_LoadWrField, i_LoadWrAddr, i_LoadWrData,
    output i_NoteValid, i_NoteVoice, i_NoteOn,
    input  o_HostWrReady, o_LoadWrReady,
    input  o_VoiceOperator, o_NoteOn,
    input  o_EnvelopeConfigWriteEnable, o_ConfigWriteAddr, o_ConfigWriteData, o_ConfigError
  );
endinterface

// File: rtl/envelope_control_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer returns to requester 0)
//   eligible   : [0] host, [1] loader; already masked by the collision guard
//   grant      : one-hot grant, combinational from eligible and the pointer
// The pointer only moves when both requesters compete, so a lone requester
// never loses its turn to an idle one.
module envelope_control_sequencer_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    case (eligible)
      2'b11: begin
        grant = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/envelope_control_sequencer.sv
// Envelope attenuator stage sequencer.
//   i_Clock, i_Reset_n : clock, async active-low reset
//   bus (slave)        : host/loader config write requests, note commands,
//                        operator sweep + NoteOn and the stage config write port
// The sweep free-runs; NoteOn commands land in a pending bank that is copied
// to the active bank on the last operator, so every operator of a voice sees
// the same NoteOn within one sweep.
module envelope_control_sequencer
  import envelope_control_sequencer_pkg::*;
(
  input logic                         i_Clock,
  input logic                         i_Reset_n,
  envelope_control_sequencer_if.slave bus
);

  VoiceOperatorID_t      op_q;
  VoiceOperatorID_t      next_op;
  logic [NUM_VOICES-1:0] pending_q;
  logic [NUM_VOICES-1:0] pending_d;
  logic [NUM_VOICES-1:0] active_q;

  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [2:0]       sel_field;
  VoiceOperatorID_t sel_addr;
  logic [15:0]      sel_data;

  logic [ENV_FIELD_COUNT-1:0] strobe_q;
  VoiceOperatorID_t           addr_q;
  logic [15:0]                data_q;
  logic                       error_q;

  // A strobe issued now lands next cycle, when the stage reads next_op.
  assign next_op     = op_q + 8'd1;
  assign eligible[0] = bus.i_HostWrValid && (bus.i_HostWrAddr != next_op);
  assign eligible[1] = bus.i_LoadWrValid && (bus.i_LoadWrAddr != next_op);

  envelope_control_sequencer_rr_arbiter2 u_arb (
    .clk      (i_Clock),
    .rst_n    (i_Reset_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign bus.o_HostWrReady = grant[0];
  assign bus.o_LoadWrReady = grant[1];

  always_comb begin
    sel_field = bus.i_HostWrField;
    sel_addr  = bus.i_HostWrAddr;
    sel_data  = bus.i_HostWrData;
    if (grant[1]) begin
      sel_field = bus.i_LoadWrField;
      sel_addr  = bus.i_LoadWrAddr;
      sel_data  = bus.i_LoadWrData;
    end
  end

  // A command arriving on the copy cycle must make it into this copy.
  always_comb begin
    pending_d = pending_q;
    if (bus.i_NoteValid) pending_d[bus.i_NoteVoice] = bus.i_NoteOn;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      op_q      <= '0;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      op_q      <= next_op;
      pending_q <= pending_d;
      if (op_q == LAST_OP) active_q <= pending_d;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      strobe_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else if (|grant) begin
      strobe_q <= field_strobe(sel_field);
      error_q  <= !field_legal(sel_field);
      addr_q   <= sel_addr;
      data_q   <= sel_data;
    end else begin
      strobe_q <= '0;
      error_q  <= 1'b0;
    end
  end

  assign bus.o_VoiceOperator             = op_q;
  assign bus.o_NoteOn                    = active_q[op_q[4:0]];
  assign bus.o_EnvelopeConfigWriteEnable = strobe_q;
  assign bus.o_ConfigWriteAddr           = addr_q;
  assign bus.o_ConfigWriteData           = data_q;
  assign bus.o_ConfigError               = error_q;

endmodule

// File: tb/tb_envelope_control_sequencer.sv
// Self-checking bench for envelope_control_sequencer: directed scenarios plus
// a randomized phase, all compared against a sweep/bank/arbitration model.
module tb_envelope_control_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  envelope_control_sequencer_if bus ();

  envelope_control_sequencer dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int   m_op;
  bit   m_pending[32];
  bit   m_active[32];
  bit   m_ptr;            // 0: host wins a tie
  logic [4:0] m_strobe;
  int   m_addr, m_data;
  bit   m_err;
  bit   m_gh, m_gl;       // grants taken at the last edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_ptr = 0; m_strobe = 0; m_addr = 0; m_data = 0; m_err = 0;
    m_gh = 0; m_gl = 0;
    for (int v = 0; v < 32; v++) begin m_pending[v] = 0; m_active[v] = 0; end
  endtask

  task automatic clear_inputs();
    bus.i_HostWrValid = 0; bus.i_HostWrField = 0; bus.i_HostWrAddr = 0; bus.i_HostWrData = 0;
    bus.i_LoadWrValid = 0; bus.i_LoadWrField = 0; bus.i_LoadWrAddr = 0; bus.i_LoadWrData = 0;
    bus.i_NoteValid = 0; bus.i_NoteVoice = 0; bus.i_NoteOn = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  // Compare this cycle's outputs with the model, then advance model and clock.
  task automatic tick();
    int  nxt, f;
    bit  he, le, gh, gl;
    nxt = (m_op + 1) % 256;
    he = bus.i_HostWrValid && (int'(bus.i_HostWrAddr) != nxt);
    le = bus.i_LoadWrValid && (int'(bus.i_LoadWrAddr) != nxt);
    gh = 0; gl = 0;
    if (he && le) begin
      if (m_ptr == 0) gh = 1; else gl = 1;
      m_ptr = !m_ptr;
    end else begin
      gh = he; gl = le;
    end
    chk("op", bus.o_VoiceOperator, m_op);
    chk("note_on", bus.o_NoteOn, m_active[m_op % 32]);
    chk("host_ready", bus.o_HostWrReady, gh);
    chk("load_ready", bus.o_LoadWrReady, gl);
    chk("strobe", bus.o_EnvelopeConfigWriteEnable, m_strobe);
    chk("cfg_err", bus.o_ConfigError, m_err);
    if (m_strobe != 0) begin
      chk("wr_addr", bus.o_ConfigWriteAddr, m_addr);
      chk("wr_data", bus.o_ConfigWriteData, m_data);
    end
    if (gh || gl) begin
      f      = gh ? int'(bus.i_HostWrField) : int'(bus.i_LoadWrField);
      m_addr = gh ? int'(bus.i_HostWrAddr)  : int'(bus.i_LoadWrAddr);
      m_data = gh ? int'(bus.i_HostWrData)  : int'(bus.i_LoadWrData);
      m_strobe = (f < 5) ? 5'(1 << f) : 5'd0;
      m_err    = (f >= 5);
    end else begin
      m_strobe = 0; m_err = 0;
    end
    if (bus.i_NoteValid) m_pending[bus.i_NoteVoice] = bus.i_NoteOn;
    if (m_op == 255) for (int v = 0; v < 32; v++) m_active[v] = m_pending[v];
    m_op = nxt;
    m_gh = gh; m_gl = gl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rst_op", bus.o_VoiceOperator, 0);
      chk("rst_note_on", bus.o_NoteOn, 0);
      chk("rst_strobe", bus.o_EnvelopeConfigWriteEnable, 0);
      chk("rst_addr", bus.o_ConfigWriteAddr, 0);
      chk("rst_data", bus.o_ConfigWriteData, 0);
      chk("rst_err", bus.o_ConfigError, 0);
      chk("rst_host_ready", bus.o_HostWrReady, 0);
      chk("rst_load_ready", bus.o_LoadWrReady, 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic new_host(input int addr, input int field);
    bus.i_HostWrValid = 1; bus.i_HostWrAddr = 8'(addr); bus.i_HostWrField = 3'(field);
    bus.i_HostWrData = 16'($urandom);
  endtask

  task automatic new_load(input int addr, input int field);
    bus.i_LoadWrValid = 1; bus.i_LoadWrAddr = 8'(addr); bus.i_LoadWrField = 3'(field);
    bus.i_LoadWrData = 16'($urandom);
  endtask

  initial begin
    int sweeps, highs;
    bit done;
    clear_inputs();
    model_reset();
    #1;
    do_reset();

    // sweep counts up from 0 and wraps after 256 cycles
    for (int k = 0; k <= 256; k++) begin
      settle();
      chk("sweep_seq", bus.o_VoiceOperator, k % 256);
      tick();
    end

    // note timing: voice 3 on at op 10 takes effect only in the next sweep
    for (int k = 0; k < 256 && m_op != 10; k++) begin settle(); tick(); end
    bus.i_NoteValid = 1; bus.i_NoteVoice = 5'd3; bus.i_NoteOn = 1;
    settle(); tick();
    bus.i_NoteValid = 0;
    sweeps = 0;
    for (int k = 0; k < 600; k++) begin
      settle();
      if (sweeps == 0 && m_op == 35) chk("note_same_sweep_op35", bus.o_NoteOn, 0);
      if (sweeps == 1 && (m_op == 3 || m_op == 35 || m_op == 227))
        chk("note_next_sweep_on", bus.o_NoteOn, 1);
      if (sweeps == 1 && m_op == 4) chk("note_next_sweep_op4", bus.o_NoteOn, 0);
      done = (sweeps == 1 && m_op == 227);
      if (m_op == 255) sweeps++;
      tick();
      if (done) break;
    end
    chk("note_test_reached", {31'd0, done}, 1);

    // arbitration: both valid, pointer at host after reset -> H, L, H, L
    do_reset();
    new_host((m_op + 100) % 256, $urandom_range(0, 4));
    new_load((m_op + 150) % 256, $urandom_range(0, 4));
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("arb_host_ready", bus.o_HostWrReady, (k % 2) == 0);
      chk("arb_load_ready", bus.o_LoadWrReady, (k % 2) == 1);
      tick();
      if (m_gh) new_host((m_op + 100) % 256, $urandom_range(0, 4));
      if (m_gl) new_load((m_op + 150) % 256, $urandom_range(0, 4));
    end
    clear_inputs();
    settle(); tick();

    // collision: host targets the operator read next cycle, loader is safe
    new_host((m_op + 1) % 256, 1);
    new_load((m_op + 90) % 256, 3);
    settle();
    chk("coll_host_stalled", bus.o_HostWrReady, 0);
    chk("coll_load_granted", bus.o_LoadWrReady, 1);
    tick();
    bus.i_LoadWrValid = 0;
    settle();
    chk("coll_host_next", bus.o_HostWrReady, 1);
    chk("coll_load_strobe", bus.o_EnvelopeConfigWriteEnable, 5'b01000);
    tick();
    bus.i_HostWrValid = 0;
    settle();
    chk("coll_host_strobe", bus.o_EnvelopeConfigWriteEnable, 5'b00010);
    tick();

    // illegal field is consumed, raises a one-cycle error, no strobe
    new_host((m_op + 60) % 256, 6);
    settle();
    chk("illegal_ready", bus.o_HostWrReady, 1);
    tick();
    bus.i_HostWrValid = 0;
    settle();
    chk("illegal_strobe", bus.o_EnvelopeConfigWriteEnable, 0);
    chk("illegal_err", bus.o_ConfigError, 1);
    tick();
    settle();
    chk("illegal_err_drop", bus.o_ConfigError, 0);
    tick();

    // mid-run reset: populate banks, grant, then reset right after the edge
    for (int v = 0; v < 32; v++) begin
      bus.i_NoteValid = 1; bus.i_NoteVoice = 5'(v); bus.i_NoteOn = (v % 3 == 0);
      settle(); tick();
    end
    bus.i_NoteValid = 0;
    for (int k = 0; k < 300 && m_op != 40; k++) begin settle(); tick(); end
    new_host((m_op + 100) % 256, 2);
    new_load((m_op + 150) % 256, 4);
    settle();
    chk("pre_reset_grant", bus.o_HostWrReady, 1);
    tick();
    do_reset();
    settle();
    chk("post_reset_strobe", bus.o_EnvelopeConfigWriteEnable, 0);
    new_host((m_op + 100) % 256, 0);
    new_load((m_op + 150) % 256, 0);
    settle();
    chk("post_reset_ptr_host", bus.o_HostWrReady, 1);
    chk("post_reset_ptr_load", bus.o_LoadWrReady, 0);
    tick();
    clear_inputs();
    highs = 0;
    for (int k = 0; k < 300; k++) begin
      settle();
      highs += int'(bus.o_NoteOn);
      tick();
    end
    chk("banks_cleared", highs, 0);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      int r;
      if (!bus.i_HostWrValid || m_gh) begin
        bus.i_HostWrValid = 0;
        if ($urandom_range(0, 9) < 6) begin
          r = $urandom_range(0, 3);
          new_host(r == 0 ? (m_op + 1) % 256 : r == 1 ? (m_op + 2) % 256 : $urandom_range(0, 255),
                   $urandom_range(0, 7));
        end
      end
      if (!bus.i_LoadWrValid || m_gl) begin
        bus.i_LoadWrValid = 0;
        if ($urandom_range(0, 9) < 6) begin
          r = $urandom_range(0, 3);
          new_load(r == 0 ? (m_op + 1) % 256 : r == 1 ? (m_op + 2) % 256 : $urandom_range(0, 255),
                   $urandom_range(0, 7));
        end
      end
      bus.i_NoteValid = ($urandom_range(0, 3) == 0);
      bus.i_NoteVoice = 5'($urandom_range(0, 31));
      bus.i_NoteOn    = 1'($urandom_range(0, 1));
      settle();
      tick();
    end
    clear_inputs();
    settle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
